// File: rtl/thread_scheduler.sv
// Four-thread round-robin issue scheduler with per-thread program counters.
// Grant, selected thread and its PC are combinational from the current state.
// Optional feature: define THREAD_SCHED_PERF_CNT_EN to add saturating
// per-thread issue counters on issue_cnt_o (tied to zero otherwise).
module thread_scheduler #(
  parameter int INSTMEM_LOG2_DEEP = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [3:0]                   thread_active_i,
  input  logic [3:0]                   thread_stall_i,
  input  logic                         issue_ready_i,
  input  logic                         redirect_valid_i,
  input  logic [1:0]                   redirect_tid_i,
  input  logic [INSTMEM_LOG2_DEEP-1:0] redirect_pc_i,
  output logic                         issue_valid_o,
  output logic [1:0]                   thread_id_o,
  output logic [INSTMEM_LOG2_DEEP-1:0] pc_select_o,
  output logic [63:0]                  issue_cnt_o
);

  localparam int PW = INSTMEM_LOG2_DEEP;
  localparam logic [PW-1:0] PC_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] pc_q [4];
  logic [1:0]    last_q;
  logic [3:0]    eligible;
  logic          grant_found;
  logic [1:0]    grant_id;
  logic [1:0]    cand;
  logic          fire;

  // A thread may be granted only when enabled and not blocked.
  always_comb begin
    eligible = thread_active_i & ~thread_stall_i;
  end

  // Round-robin search starting just after the last granted thread.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = 2'd0;
    cand        = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + k[1:0];
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Outputs are forced to zero when nothing is eligible.
  always_comb begin
    issue_valid_o = grant_found;
    thread_id_o   = grant_found ? grant_id : 2'd0;
    pc_select_o   = grant_found ? pc_q[grant_id] : '0;
    fire          = grant_found & issue_ready_i;
  end

  // PC and pointer update; the redirect is written last so it overrides the increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        pc_q[i] <= '0;
      end
      last_q <= 2'd3;
    end else begin
      if (fire) begin
        last_q         <= grant_id;
        pc_q[grant_id] <= pc_q[grant_id] + PC_ONE;
      end
      if (redirect_valid_i) begin
        pc_q[redirect_tid_i] <= redirect_pc_i;
      end
    end
  end

`ifdef THREAD_SCHED_PERF_CNT_EN
  logic [15:0] cnt_q [4];

  // Saturating issue counter for the thread that fires this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else if (fire && (cnt_q[grant_id] != 16'hFFFF)) begin
      cnt_q[grant_id] <= cnt_q[grant_id] + 16'd1;
    end
  end

  // Pack thread n's counter into bits [16n+15:16n].
  always_comb begin
    issue_cnt_o = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
  end
`else
  // No counters in this build; the port reads zero.
  always_comb begin
    issue_cnt_o = 64'd0;
  end
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Scoreboard bench for thread_scheduler: a driver issues stimulus and pushes
// the reference model's expected outputs; a monitor pops and compares them.
module tb_thread_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  thread_active_i = 4'h0;
  logic [3:0]  thread_stall_i = 4'h0;
  logic        issue_ready_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [1:0]  redirect_tid_i = 2'd0;
  logic [7:0]  redirect_pc_i = 8'd0;
  logic        issue_valid_o;
  logic [1:0]  thread_id_o;
  logic [7:0]  pc_select_o;
  logic [63:0] issue_cnt_o;

  typedef struct {
    logic        valid;
    logic [1:0]  tid;
    logic [7:0]  pc;
    logic [63:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: plain integers.
  int m_pc[4];
  int m_cnt[4];
  int m_last;

  thread_scheduler #(.INSTMEM_LOG2_DEEP(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .thread_active_i  (thread_active_i),
    .thread_stall_i   (thread_stall_i),
    .issue_ready_i    (issue_ready_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_tid_i   (redirect_tid_i),
    .redirect_pc_i    (redirect_pc_i),
    .issue_valid_o    (issue_valid_o),
    .thread_id_o      (thread_id_o),
    .pc_select_o      (pc_select_o),
    .issue_cnt_o      (issue_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pc[i]  = 0;
      m_cnt[i] = 0;
    end
    m_last = 3;
  endfunction

  // One cycle: drive inputs at negedge, predict outputs, then advance the model.
  task automatic applyStimulus(input logic rst, input logic [3:0] act, input logic [3:0] stl,
                               input logic rdy, input logic rv, input logic [1:0] rt,
                               input logic [7:0] rpc);
    exp_t e;
    logic [3:0] elig;
    int c;
    @(negedge clk_i);
    rst_ni           = rst;
    thread_active_i  = act;
    thread_stall_i   = stl;
    issue_ready_i    = rdy;
    redirect_valid_i = rv;
    redirect_tid_i   = rt;
    redirect_pc_i    = rpc;
    if (!rst) model_reset();
    elig    = act & ~stl;
    e.valid = 1'b0;
    e.tid   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      c = (m_last + k) % 4;
      if (!e.valid && elig[c]) begin
        e.valid = 1'b1;
        e.tid   = c[1:0];
      end
    end
    e.pc = e.valid ? 8'(m_pc[e.tid]) : 8'h00;
`ifdef THREAD_SCHED_PERF_CNT_EN
    e.cnt = {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])};
`else
    e.cnt = 64'd0;
`endif
    exp_q.push_back(e);
    if (rst) begin
      if (e.valid && rdy) begin
        m_last     = e.tid;
        m_pc[e.tid] = (m_pc[e.tid] + 1) % 256;
        if (m_cnt[e.tid] < 65535) m_cnt[e.tid] = m_cnt[e.tid] + 1;
      end
      if (rv) m_pc[rt] = rpc;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (issue_valid_o !== e.valid) begin
      errors++;
      $display("[TB] FAIL issue_valid got=%b want=%b t=%0t", issue_valid_o, e.valid, $time);
    end
    checks++;
    if (thread_id_o !== e.tid) begin
      errors++;
      $display("[TB] FAIL thread_id got=%0d want=%0d t=%0t", thread_id_o, e.tid, $time);
    end
    checks++;
    if (pc_select_o !== e.pc) begin
      errors++;
      $display("[TB] FAIL pc_select got=%h want=%h t=%0t", pc_select_o, e.pc, $time);
    end
    checks++;
    if (issue_cnt_o !== e.cnt) begin
      errors++;
      $display("[TB] FAIL issue_cnt got=%h want=%h t=%0t", issue_cnt_o, e.cnt, $time);
    end
  endtask

  // Monitor: compares the DUT's presented outputs against the oldest prediction.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    int rnd_active, rnd_stall;
    model_reset();
    $display("[TB] start");
    // Reset held, then the four-way rotation.
    repeat (2) applyStimulus(1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00);
    repeat (8) applyStimulus(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00);
    // Thread 1 stalled: it is skipped and its PC does not move.
    repeat (8) applyStimulus(1'b1, 4'hF, 4'b0010, 1'b1, 1'b0, 2'd0, 8'h00);
    // Park the pointer on thread 1, then hold ready low while thread 2 is granted.
    applyStimulus(1'b1, 4'b0010, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00);
    repeat (3) applyStimulus(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (2) applyStimulus(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00);
    // Redirect collides with a fire of thread 1; the redirect wins.
    applyStimulus(1'b1, 4'b0010, 4'h0, 1'b1, 1'b1, 2'd1, 8'hA0);
    applyStimulus(1'b1, 4'b0010, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
    // Nothing active, redirect an idle thread to the top of memory, then wrap it.
    applyStimulus(1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 8'hFF);
    applyStimulus(1'b1, 4'b1000, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00);
    applyStimulus(1'b1, 4'b1000, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
    // Randomised traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      rnd_active = $urandom_range(0, 15);
      rnd_stall  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
      applyStimulus(1'b1, 4'(rnd_active), 4'(rnd_stall), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)));
    end
    // Reset pulse mid-run drops the in-flight grant.
    applyStimulus(1'b0, 4'hF, 4'h0, 1'b1, 1'b1, 2'd2, 8'h55);
    repeat (3) applyStimulus(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00);
`ifdef THREAD_SCHED_PERF_CNT_EN
    // Saturate thread 0's counter, then reset mid-run.
    repeat (70000) applyStimulus(1'b1, 4'b0001, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00);
    applyStimulus(1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00);
    repeat (2) applyStimulus(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 8'h00);
`endif
    repeat (2) @(negedge clk_i);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
